// File: rtl/mips_gpio_responder_if.sv
// Data-memory bus bundle between the MIPS core (master) and the GPIO responder (slave).
interface mips_gpio_responder_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output sel, output we, output addr, output wd, input rd);
  modport slave  (input sel, input we, input addr, input wd, output rd);
endinterface

// File: rtl/mips_gpio_responder.sv
// Memory-mapped GPIO responder: two output registers, two synchronised inputs,
// sticky W1C change status with level interrupt and a saturating gpi1 change counter.
module mips_gpio_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] GPO_RST     = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_gpio_responder_if.slave        bus,
  input  logic [31:0]                 gpi1,
  input  logic [31:0]                 gpi2,
  output logic [31:0]                 gpo1,
  output logic [31:0]                 gpo2,
  output logic                        chg_irq
);

  typedef enum logic [2:0] {
    REG_GPI1    = 3'd0,
    REG_GPI2    = 3'd1,
    REG_GPO1    = 3'd2,
    REG_GPO2    = 3'd3,
    REG_STATUS  = 3'd4,
    REG_CHG_CNT = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_off_e;

  reg_off_e                         off;
  logic                             wr;
  logic [SYNC_STAGES-1:0][31:0]     sync1, sync2;
  logic [31:0]                      gpi1_s, gpi2_s, prev1, prev2;
  logic                             chg1, chg2;
  logic [1:0]                       status, status_nxt;
  logic [CNT_W-1:0]                 chg_cnt, cnt_nxt;
  logic                             unused_addr;

  assign off         = reg_off_e'(bus.addr[4:2]);
  assign wr          = bus.sel && bus.we;
  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};

  assign gpi1_s = sync1[SYNC_STAGES-1];
  assign gpi2_s = sync2[SYNC_STAGES-1];
  assign chg1   = (gpi1_s != prev1);
  assign chg2   = (gpi2_s != prev2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], gpi1};
      sync2 <= {sync2[SYNC_STAGES-2:0], gpi2};
    end
  end

  // New changes are OR-ed in after the W1C mask so a same-cycle set wins;
  // likewise a counter clear is applied before the increment.
  always_comb begin
    status_nxt = status;
    if (wr && off == REG_STATUS)
      status_nxt = status & ~bus.wd[1:0];
    status_nxt = status_nxt | {chg2, chg1};

    cnt_nxt = chg_cnt;
    if (wr && off == REG_CHG_CNT)
      cnt_nxt = '0;
    if (chg1 && cnt_nxt != '1)
      cnt_nxt = cnt_nxt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpo1    <= GPO_RST;
      gpo2    <= GPO_RST;
      prev1   <= '0;
      prev2   <= '0;
      status  <= '0;
      chg_cnt <= '0;
    end else begin
      prev1   <= gpi1_s;
      prev2   <= gpi2_s;
      status  <= status_nxt;
      chg_cnt <= cnt_nxt;
      if (wr && off == REG_GPO1)
        gpo1 <= bus.wd;
      if (wr && off == REG_GPO2)
        gpo2 <= bus.wd;
    end
  end

  assign chg_irq = |status;

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (off)
        REG_GPI1:    bus.rd = gpi1_s;
        REG_GPI2:    bus.rd = gpi2_s;
        REG_GPO1:    bus.rd = gpo1;
        REG_GPO2:    bus.rd = gpo2;
        REG_STATUS:  bus.rd = {30'd0, status};
        REG_CHG_CNT: bus.rd = 32'(chg_cnt);
        default:     bus.rd = '0;
      endcase
    end
  end

endmodule
